// File: rtl/if_trace_buffer_pkg.sv
// Shared trace types for the instruction-fetch trace path.
package ryuki_datatypes;

   localparam int TRACE_BUFFER_DEPTH = 8;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] instr;
   } trace_output;

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_PARTIAL = 2'd1,
      ST_FULL    = 2'd2
   } fifo_state_e;

endpackage

// File: rtl/if_trace_buffer_trace_fifo.sv
// Circular storage for trace records: pointers, occupancy and full/empty state.
module trace_fifo
   import ryuki_datatypes::*;
#(
   parameter int DEPTH = TRACE_BUFFER_DEPTH,
   parameter int WIDTH = 64,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = PW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic [CW-1:0]    fill_level_o,
   output logic             full_o,
   output logic             empty_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wptr_q;
   logic [PW-1:0]    rptr_q;
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_d;
   fifo_state_e      state_q;
   logic             do_push_s;
   logic             do_pop_s;

   // A push into a full buffer is only taken when the head leaves on the same edge.
   assign do_pop_s  = pop_i & (state_q != ST_EMPTY) & ~flush_i;
   assign do_push_s = push_i & ~flush_i & ((state_q != ST_FULL) | do_pop_s);

   always_comb begin
      count_d = count_q;
      if (do_push_s && !do_pop_s) begin
         count_d = count_q + CW'(1);
      end else if (do_pop_s && !do_push_s) begin
         count_d = count_q - CW'(1);
      end else begin
         count_d = count_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         state_q <= ST_EMPTY;
      end else if (flush_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         state_q <= ST_EMPTY;
      end else begin
         if (do_push_s) wptr_q <= wptr_q + PW'(1);
         if (do_pop_s)  rptr_q <= rptr_q + PW'(1);
         count_q <= count_d;
         case (state_q)
            ST_EMPTY:   if (do_push_s) state_q <= ST_PARTIAL;
            ST_PARTIAL: begin
               if (do_push_s && !do_pop_s && count_q == CW'(DEPTH - 1)) state_q <= ST_FULL;
               else if (do_pop_s && !do_push_s && count_q == CW'(1)) state_q <= ST_EMPTY;
            end
            ST_FULL:    if (do_pop_s && !do_push_s) state_q <= ST_PARTIAL;
            default:    state_q <= ST_EMPTY;
         endcase
      end
   end

   // Storage is deliberately left out of reset; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (do_push_s) mem_q[wptr_q] <= data_i;
   end

   assign data_o       = mem_q[rptr_q];
   assign fill_level_o = count_q;
   assign full_o       = (state_q == ST_FULL);
   assign empty_o      = (state_q == ST_EMPTY);

endmodule

// File: rtl/if_trace_buffer.sv
// Fetch trace buffer: turns rising edges of if_data_ready into records and
// queues them for a ready/valid consumer, counting records lost to overflow.
module if_trace_buffer
   import ryuki_datatypes::*;
#(
   parameter int DEPTH      = TRACE_BUFFER_DEPTH,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   localparam int CW = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_data_ready,
   input  trace_output   if_data_i,
   input  logic          flush,
   input  logic          trace_ready,
   output logic          trace_valid,
   output trace_output   trace_data_o,
   output logic [CW-1:0] fill_level,
   output logic          full,
   output logic          empty,
   output logic          overflow,
   output logic [31:0]   dropped_count
);

   localparam int W = ADDR_WIDTH + DATA_WIDTH;

   logic          ready_q;
   logic          overflow_q;
   logic          overflow_d;
   logic [31:0]   dropped_q;
   logic [31:0]   dropped_d;
   logic          push_ev_s;
   logic          pop_s;
   logic          drop_s;
   logic [W-1:0]  fifo_out_s;

   assign push_ev_s = if_data_ready & ~ready_q;
   assign pop_s     = trace_ready & trace_valid;
   // A flush on the same edge swallows the push, so it is never a drop.
   assign drop_s    = push_ev_s & full & ~pop_s & ~flush;

   trace_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (W)
   ) u_fifo (
      .clk          (clk),
      .rst          (rst),
      .flush_i      (flush),
      .push_i       (push_ev_s),
      .pop_i        (pop_s),
      .data_i       (if_data_i),
      .data_o       (fifo_out_s),
      .fill_level_o (fill_level),
      .full_o       (full),
      .empty_o      (empty)
   );

   always_comb begin
      dropped_d  = dropped_q;
      overflow_d = overflow_q;
      if (drop_s) begin
         overflow_d = 1'b1;
         if (dropped_q != 32'hFFFF_FFFF) dropped_d = dropped_q + 32'd1;
         else dropped_d = dropped_q;
      end else begin
         dropped_d  = dropped_q;
         overflow_d = overflow_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ready_q    <= 1'b0;
         overflow_q <= 1'b0;
         dropped_q  <= 32'd0;
      end else begin
         ready_q    <= if_data_ready;
         overflow_q <= overflow_d;
         dropped_q  <= dropped_d;
      end
   end

   assign trace_valid   = ~empty;
   assign trace_data_o  = trace_output'(fifo_out_s);
   assign overflow      = overflow_q;
   assign dropped_count = dropped_q;

endmodule

// File: tb/tb_if_trace_buffer.sv
// Scoreboard bench for if_trace_buffer: directed scenarios plus random traffic.
module tb_if_trace_buffer;
   import ryuki_datatypes::*;

   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          if_data_ready = 1'b0;
   logic          flush = 1'b0;
   logic          trace_ready = 1'b0;
   trace_output   if_data_i = '0;
   logic          trace_valid;
   trace_output   trace_data_o;
   logic [CW-1:0] fill_level;
   logic          full;
   logic          empty;
   logic          overflow;
   logic [31:0]   dropped_count;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: occupancy, drop accounting and the ordered list of expected records.
   trace_output exp_q[$];
   int          m_cnt  = 0;
   bit          m_prev = 1'b0;
   bit          m_ovf  = 1'b0;
   logic [31:0] m_drop = 32'd0;

   if_trace_buffer #(.DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst           (rst),
      .if_data_ready (if_data_ready),
      .if_data_i     (if_data_i),
      .flush         (flush),
      .trace_ready   (trace_ready),
      .trace_valid   (trace_valid),
      .trace_data_o  (trace_data_o),
      .fill_level    (fill_level),
      .full          (full),
      .empty         (empty),
      .overflow      (overflow),
      .dropped_count (dropped_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_cnt  = 0;
         m_prev = 1'b0;
         m_ovf  = 1'b0;
         m_drop = 32'd0;
         exp_q.delete();
      end else begin
         bit push, pop;
         push   = if_data_ready && !m_prev;
         pop    = trace_ready && (m_cnt > 0);
         m_prev = if_data_ready;
         if (flush) begin
            m_cnt = 0;
            exp_q.delete();
         end else begin
            if (pop) m_cnt--;
            if (push) begin
               if (m_cnt < DEPTH) begin
                  m_cnt++;
                  exp_q.push_back(if_data_i);
               end else begin
                  m_ovf = 1'b1;
                  if (m_drop != 32'hFFFF_FFFF) m_drop++;
               end
            end
         end
      end
   end

   // Monitor: status every cycle, head record against the scoreboard, pop on handshake.
   always @(negedge clk) begin
      if (!rst) begin
         check("fill_level", fill_level, m_cnt);
         check("trace_valid", trace_valid, m_cnt != 0);
         check("full", full, m_cnt == DEPTH);
         check("empty", empty, m_cnt == 0);
         check("overflow", overflow, m_ovf);
         check("dropped_count", dropped_count, m_drop);
         if (trace_valid) begin
            check("sb_has_head", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
               check("head_data", trace_data_o, exp_q[0]);
               if (trace_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic drive(input bit rdy, input logic [31:0] addr, input bit fl, input bit tr);
      if_data_ready   = rdy;
      if_data_i.addr  = addr;
      if_data_i.instr = $urandom;
      flush           = fl;
      trace_ready     = tr;
      @(posedge clk);
      #2;
   endtask

   task automatic push_one(input logic [31:0] addr);
      drive(1'b1, addr, 1'b0, 1'b0);
      drive(1'b0, 32'd0, 1'b0, 1'b0);
   endtask

   task automatic drain();
      for (int i = 0; i < 64 && fill_level != '0; i++) drive(1'b0, 32'd0, 1'b0, 1'b1);
      check("drain_done", fill_level, 0);
      trace_ready = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b0;
      check("rst_fill", fill_level, 0);
      check("rst_empty", empty, 1'b1);
      check("rst_full", full, 1'b0);
      check("rst_valid", trace_valid, 1'b0);
      check("rst_overflow", overflow, 1'b0);
      check("rst_dropped", dropped_count, 0);

      drive(1'b1, 32'h100, 1'b0, 1'b0);
      check("first_valid", trace_valid, 1'b1);
      check("first_addr", trace_data_o.addr, 32'h100);
      check("first_fill", fill_level, 1);
      drive(1'b0, 32'd0, 1'b0, 1'b0);
      drain();

      for (int i = 0; i < 5; i++) drive(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0);
      drive(1'b0, 32'd0, 1'b0, 1'b0);
      check("held_level_one_push", fill_level, 1);
      drain();

      for (int i = 1; i <= 10; i++) push_one(32'h1000 + 32'(i));
      check("ovf_full", full, 1'b1);
      check("ovf_fill", fill_level, 8);
      check("ovf_dropped", dropped_count, 2);
      check("ovf_flag", overflow, 1'b1);
      check("ovf_head", trace_data_o.addr, 32'h1001);
      drain();

      for (int i = 0; i < 8; i++) push_one(32'h2000 + 32'(i));
      drive(1'b1, 32'h2008, 1'b0, 1'b1);
      check("full_pushpop_fill", fill_level, 8);
      check("full_pushpop_dropped", dropped_count, 2);
      for (int i = 0; i < 20; i++) begin
         drive(1'b0, 32'd0, 1'b0, 1'b0);
         drive(1'b1, 32'h3000 + 32'(i), 1'b0, 1'b1);
      end
      check("wrap_fill", fill_level, 8);
      check("wrap_dropped", dropped_count, 2);
      drain();

      for (int i = 0; i < 3; i++) push_one(32'h4000 + 32'(i));
      check("preflush_fill", fill_level, 3);
      drive(1'b1, 32'h4003, 1'b1, 1'b0);
      check("flush_fill", fill_level, 0);
      check("flush_valid", trace_valid, 1'b0);
      check("flush_dropped", dropped_count, 2);
      drive(1'b0, 32'd0, 1'b0, 1'b0);

      for (int i = 0; i < 600; i++) begin
         drive(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 40) == 0),
               ($urandom_range(0, 9) < ((i < 300) ? 2 : 7)));
      end
      drain();

      for (int i = 0; i < 6; i++) push_one(32'h5000 + 32'(i));
      drive(1'b0, 32'd0, 1'b0, 1'b1);
      check("middrain_fill", fill_level, 5);
      #2;
      if_data_ready = 1'b1;
      rst = 1'b1;
      #1;
      check("async_rst_valid", trace_valid, 1'b0);
      check("async_rst_fill", fill_level, 0);
      check("async_rst_dropped", dropped_count, 0);
      trace_ready = 1'b0;
      @(posedge clk);
      #2;
      rst = 1'b0;
      @(posedge clk);
      #2;
      check("post_rst_push_fill", fill_level, 1);
      check("post_rst_push_valid", trace_valid, 1'b1);
      drive(1'b1, 32'd0, 1'b0, 1'b1);
      drive(1'b0, 32'd0, 1'b0, 1'b0);
      check("post_rst_final_fill", fill_level, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/if_trace_buffer.md
IF_TRACE_BUFFER -- requirements
Module: if_trace_buffer

Interface
REQ-001 Parameter DEPTH, default 8, number of trace_output entries held; SHALL be a power of two, at least 2.
REQ-002 Parameter ADDR_WIDTH, default 32, address width carried in trace_output.
REQ-003 Parameter DATA_WIDTH, default 32, instruction width carried in trace_output.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 if_data_ready  input  1  level from the fetch tracker; a 0->1 transition marks one new record.
REQ-007 if_data_i  input  trace_output  fetch record; valid on the edge where the transition is detected.
REQ-008 flush  input  1  synchronous discard of all held entries.
REQ-009 trace_ready  input  1  downstream consumer accepts the head entry.
REQ-010 trace_valid  output  1  head entry present.
REQ-011 trace_data_o  output  trace_output  head entry.
REQ-012 fill_level  output  $clog2(DEPTH)+1  entries currently held.
REQ-013 full / empty  output  1 each  fill_level==DEPTH / fill_level==0.
REQ-014 overflow  output  1  sticky; set on the first dropped record.
REQ-015 dropped_count  output  32  records dropped since reset; saturates at 32'hFFFF_FFFF.

Function
REQ-016 Capture: registered copy ready_q of if_data_ready; push event = if_data_ready & ~ready_q at a rising edge; a level held high SHALL produce exactly one push.
REQ-017 Push: writes if_data_i at the write pointer on the same edge; the entry is visible on trace_data_o, with trace_valid=1, from that edge when the buffer was empty (1-cycle latency).
REQ-018 Pop: trace_valid & trace_ready at a rising edge; advances the read pointer; trace_data_o presents the next entry after that edge.
REQ-019 trace_valid = ~empty; trace_data_o SHALL be stable while trace_valid=1 and trace_ready=0.
REQ-020 Pointers are log2(DEPTH) bits and wrap from DEPTH-1 to 0; no gap or reorder at the wrap.
REQ-021 Push and pop on the same edge, non-empty: fill_level unchanged; both pointers advance.
REQ-022 Push while full with a simultaneous pop: accepted, no drop.
REQ-023 Push while full without pop: record discarded; the held contents are unchanged; dropped_count increments unless saturated; overflow set.
REQ-024 Pop while empty is impossible: trace_valid=0, so trace_ready is ignored.
REQ-025 flush: at the edge, pointers and fill_level go to 0; a push or pop on the same edge is ignored and a push is not counted as dropped; overflow and dropped_count are retained.
REQ-026 Precedence per edge: rst > flush > push/pop.
REQ-027 Storage state machine, derived from fill_level: EMPTY -> PARTIAL on push; PARTIAL -> FULL when push without pop reaches DEPTH; FULL -> PARTIAL on pop without push; PARTIAL -> EMPTY when pop without push reaches 0; any state -> EMPTY on flush.

Reset
REQ-028 rst asserted: immediately clear pointers, fill_level=0, empty=1, full=0, trace_valid=0, overflow=0, dropped_count=0, ready_q=0; the storage array is not cleared.
REQ-029 trace_data_o is don't-care while trace_valid=0, including during reset.
REQ-030 After rst deasserts with if_data_ready already 1, the first edge SHALL count as a push.
REQ-031 rst during an in-flight push or pop: that transaction is lost, nothing is counted, and the state is as in REQ-028.

Structure
REQ-032 trace_output stays in package ryuki_datatypes; add a constant TRACE_BUFFER_DEPTH (8) to the same package.
REQ-033 One sub-module, trace_fifo (storage, pointers, fill_level, full/empty); if_trace_buffer holds edge detection, flush gating, and overflow/dropped_count.

Verification
REQ-034 Reset, then pulse if_data_ready for 1 cycle with addr=0x100, trace_ready=0 -> next cycle trace_valid=1, trace_data_o.addr=0x100, fill_level=1.
REQ-035 Hold if_data_ready high for 5 cycles -> exactly one push; fill_level=1.
REQ-036 DEPTH=8: 10 pushes with trace_ready=0 -> full=1, fill_level=8, dropped_count=2, overflow=1; drain -> addrs in push order, entries 9-10 absent.
REQ-037 Fill to 8, then push and pop on the same edge -> no drop, fill_level=8; 20 push/pop cycles across the wrap keep the order intact.
REQ-038 fill_level=3, flush asserted together with a push -> fill_level=0, trace_valid=0, dropped_count unchanged.
REQ-039 Assert rst asynchronously mid-drain at fill_level=5 -> trace_valid=0 and fill_level=0 before the next clock edge.
